// File: rtl/aexm_ifetch.sv
// Instruction-fetch stage: issues sequential word requests to the I-cache, buffers returned
// words in a 2-entry prefetch queue and handles taken branches with or without a delay slot.
module aexm_ifetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h8800_0000
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        d_en,
  input  logic        rBRA,
  input  logic        rDLY,
  input  logic [31:0] rBPC,
  output logic        ic_req,
  output logic [29:0] ic_adr,
  input  logic        ic_ack,
  input  logic [31:0] ic_dat,
  output logic [31:0] aexm_icache_datai,
  output logic [31:0] rIPC,
  output logic        f_stall
);

  logic [31:0] fetchPc, fetchPcNext;
  logic [1:0]  qCnt, qCntNext;
  logic [31:0] q0Word, q0WordNext, q0Pc, q0PcNext;
  logic [31:0] q1Word, q1WordNext, q1Pc, q1PcNext;
  logic        squash, squashNext;
  logic [29:0] tgtPc, tgtPcNext;

  logic pop, push, branch;

  assign pop    = d_en && (qCnt != 2'd0);
  assign branch = d_en && rBRA;
  // While waiting for an unfetched delay slot, exactly one word may enter the queue.
  assign ic_req = grst && (squash ? (qCnt == 2'd0) : ((qCnt != 2'd2) || pop));
  assign push   = ic_req && ic_ack && !branch;
  assign ic_adr = fetchPc[31:2];

  assign aexm_icache_datai = (qCnt != 2'd0) ? q0Word : NOP_WORD;
  assign rIPC              = (qCnt != 2'd0) ? q0Pc : fetchPc;
  assign f_stall           = (qCnt == 2'd0);

  always_comb begin
    fetchPcNext = fetchPc;
    qCntNext    = qCnt;
    q0WordNext  = q0Word;
    q0PcNext    = q0Pc;
    q1WordNext  = q1Word;
    q1PcNext    = q1Pc;
    squashNext  = squash;
    tgtPcNext   = tgtPc;

    if (push) fetchPcNext = fetchPc + 32'd4;

    unique case ({push, pop})
      2'b10: begin
        if (qCnt == 2'd0) begin
          q0WordNext = ic_dat;
          q0PcNext   = fetchPc;
        end else begin
          q1WordNext = ic_dat;
          q1PcNext   = fetchPc;
        end
        qCntNext = qCnt + 2'd1;
      end
      2'b01: begin
        q0WordNext = q1Word;
        q0PcNext   = q1Pc;
        qCntNext   = qCnt - 2'd1;
      end
      2'b11: begin
        if (qCnt == 2'd1) begin
          q0WordNext = ic_dat;
          q0PcNext   = fetchPc;
        end else begin
          q0WordNext = q1Word;
          q0PcNext   = q1Pc;
          q1WordNext = ic_dat;
          q1PcNext   = fetchPc;
        end
      end
      default: ;
    endcase

    // Delay slot has just been consumed: resume at the saved target.
    if (squash && pop) begin
      fetchPcNext = {tgtPc, 2'b00};
      squashNext  = 1'b0;
    end

    if (branch) begin
      qCntNext = 2'd0;
      if (rDLY && (qCnt == 2'd0)) begin
        squashNext  = 1'b1;
        tgtPcNext   = rBPC[31:2];
        fetchPcNext = fetchPc;
      end else begin
        fetchPcNext = {rBPC[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      fetchPc <= PC_RESET;
      qCnt    <= 2'd0;
      q0Word  <= NOP_WORD;
      q0Pc    <= 32'd0;
      q1Word  <= NOP_WORD;
      q1Pc    <= 32'd0;
      squash  <= 1'b0;
      tgtPc   <= 30'd0;
    end else begin
      fetchPc <= fetchPcNext;
      qCnt    <= qCntNext;
      q0Word  <= q0WordNext;
      q0Pc    <= q0PcNext;
      q1Word  <= q1WordNext;
      q1Pc    <= q1PcNext;
      squash  <= squashNext;
      tgtPc   <= tgtPcNext;
    end
  end

  assert property (@(posedge gclk) disable iff (!grst)
    !(ic_req && ic_ack && (qCnt == 2'd2) && !pop));

  assert property (@(posedge gclk) disable iff (!grst)
    !(squash && d_en && rBRA));

endmodule
